// File: rtl/divider_pkg.sv
// Shared definitions for the programmable pulse divider and its configuration sequencer.
package divider_pkg;

  localparam int unsigned DEFAULT_DIV_WIDTH = 32;
  localparam int unsigned MIN_DIVISOR       = 2;

  typedef enum logic [2:0] {
    StIdle,
    StQuiesce,
    StSrClear,
    StShiftLo,
    StShiftHi,
    StSrFinish,
    StCntReset
  } seq_state_e;

endpackage

// File: rtl/divider_sr_serializer.sv
// Holds the pending divisor and shifts it MSB-first into the divider shift register,
// generating the SR data clock with a programmable half period.
module divider_sr_serializer
  import divider_pkg::*;
#(
  parameter int unsigned DIV_WIDTH      = DEFAULT_DIV_WIDTH,
  parameter int unsigned SR_HALF_PERIOD = 1
) (
  input  logic                 sys_clock,
  input  logic                 sys_reset_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_divisor,
  input  logic                 start,
  output logic [DIV_WIDTH-1:0] shadow,
  output logic                 phase_end,
  output logic                 done,
  output logic                 div_sr_data,
  output logic                 div_sr_data_clock
);

  localparam int unsigned BitW  = (DIV_WIDTH > 1) ? $clog2(DIV_WIDTH) : 1;
  localparam int unsigned HalfW = (SR_HALF_PERIOD > 1) ? $clog2(SR_HALF_PERIOD) : 1;
  localparam logic [BitW-1:0]  LastBit  = BitW'(DIV_WIDTH - 1);
  localparam logic [HalfW-1:0] HalfLast = HalfW'(SR_HALF_PERIOD - 1);

  logic [DIV_WIDTH-1:0] shadow_q;
  logic [BitW-1:0]      bit_q;
  logic [HalfW-1:0]     half_q;
  logic                 hi_q, active_q, data_q, sclk_q;

  // Last cycle of the current half period; done marks the end of bit 0's high phase.
  assign phase_end         = active_q & (half_q == HalfLast);
  assign done              = phase_end & hi_q & (bit_q == '0);
  assign shadow            = shadow_q;
  assign div_sr_data       = data_q;
  assign div_sr_data_clock = sclk_q;

  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      shadow_q <= '0;
      bit_q    <= '0;
      half_q   <= '0;
      hi_q     <= 1'b0;
      active_q <= 1'b0;
      data_q   <= 1'b0;
      sclk_q   <= 1'b0;
    end else begin
      if (load) begin
        shadow_q <= load_divisor;
      end
      if (start) begin
        active_q <= 1'b1;
        hi_q     <= 1'b0;
        half_q   <= '0;
        bit_q    <= LastBit;
        data_q   <= shadow_q[DIV_WIDTH-1];
        sclk_q   <= 1'b0;
      end else if (active_q) begin
        if (!phase_end) begin
          half_q <= half_q + HalfW'(1);
        end else begin
          half_q <= '0;
          if (!hi_q) begin
            hi_q   <= 1'b1;
            sclk_q <= 1'b1;
          end else if (bit_q == '0) begin
            active_q <= 1'b0;
            hi_q     <= 1'b0;
            sclk_q   <= 1'b0;
            data_q   <= 1'b0;
          end else begin
            bit_q  <= bit_q - BitW'(1);
            hi_q   <= 1'b0;
            sclk_q <= 1'b0;
            data_q <= shadow_q[bit_q - BitW'(1)];
          end
        end
      end
    end
  end

endmodule

// File: rtl/divider_config_sequencer.sv
// Control-side sequencer: accepts a divisor, runs the divider reprogram sequence and issues
// counter-only restarts. All outputs except cfg_ready are registered.
module divider_config_sequencer
  import divider_pkg::*;
#(
  parameter int unsigned DIV_WIDTH          = DEFAULT_DIV_WIDTH,
  parameter int unsigned SR_HALF_PERIOD     = 1,
  parameter int unsigned SETTLE_CYCLES      = 1,
  parameter int unsigned RESET_PULSE_CYCLES = 2
) (
  input  logic                 sys_clock,
  input  logic                 sys_reset_n,
  input  logic [DIV_WIDTH-1:0] cfg_divisor,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 counter_restart,
  input  logic                 run_request,
  output logic                 busy,
  output logic                 load_done,
  output logic                 cfg_error,
  output logic [DIV_WIDTH-1:0] loaded_divisor,
  output logic                 div_enable,
  output logic                 div_external_reset,
  output logic                 div_sr_data,
  output logic                 div_sr_data_clock,
  output logic                 div_sr_enable,
  output logic                 div_sr_reset
);

  localparam int unsigned TimMax = (SETTLE_CYCLES > RESET_PULSE_CYCLES) ? SETTLE_CYCLES
                                                                       : RESET_PULSE_CYCLES;
  localparam int unsigned TimW   = (TimMax > 1) ? $clog2(TimMax) : 1;
  localparam logic [TimW-1:0] SettleLast = TimW'(SETTLE_CYCLES - 1);
  localparam logic [TimW-1:0] ResetLast  = TimW'(RESET_PULSE_CYCLES - 1);

  seq_state_e           state_q;
  logic [TimW-1:0]      timer_q;
  logic                 loaded_valid_q;
  logic [DIV_WIDTH-1:0] loaded_divisor_q;
  logic                 busy_q, load_done_q, cfg_error_q, enable_q;
  logic                 ext_reset_q, sr_enable_q, sr_reset_q;

  logic                 accept, divisor_ok, sr_load, sr_start, sr_phase_end, sr_done;
  logic [DIV_WIDTH-1:0] sr_shadow;

  assign cfg_ready  = (state_q == StIdle);
  assign accept     = cfg_valid & cfg_ready;
  assign divisor_ok = (cfg_divisor >= DIV_WIDTH'(MIN_DIVISOR));
  assign sr_load    = accept & divisor_ok;
  assign sr_start   = (state_q == StSrClear);

  divider_sr_serializer #(
    .DIV_WIDTH      (DIV_WIDTH),
    .SR_HALF_PERIOD (SR_HALF_PERIOD)
  ) u_serializer (
    .sys_clock         (sys_clock),
    .sys_reset_n       (sys_reset_n),
    .load              (sr_load),
    .load_divisor      (cfg_divisor),
    .start             (sr_start),
    .shadow            (sr_shadow),
    .phase_end         (sr_phase_end),
    .done              (sr_done),
    .div_sr_data       (div_sr_data),
    .div_sr_data_clock (div_sr_data_clock)
  );

  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q          <= StIdle;
      timer_q          <= '0;
      loaded_valid_q   <= 1'b0;
      loaded_divisor_q <= '0;
      busy_q           <= 1'b0;
      load_done_q      <= 1'b0;
      cfg_error_q      <= 1'b0;
      enable_q         <= 1'b0;
      ext_reset_q      <= 1'b0;
      sr_enable_q      <= 1'b0;
      sr_reset_q       <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      cfg_error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // A reload also resets the counter, so a coincident restart is dropped.
          if (accept && divisor_ok) begin
            state_q  <= StQuiesce;
            timer_q  <= '0;
            busy_q   <= 1'b1;
            enable_q <= 1'b0;
          end else if (!accept && counter_restart && loaded_valid_q) begin
            state_q     <= StCntReset;
            timer_q     <= '0;
            busy_q      <= 1'b1;
            enable_q    <= 1'b0;
            ext_reset_q <= 1'b1;
          end else begin
            cfg_error_q <= accept;
            enable_q    <= run_request & loaded_valid_q;
          end
        end
        StQuiesce: begin
          if (timer_q == SettleLast) begin
            state_q    <= StSrClear;
            timer_q    <= '0;
            sr_reset_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TimW'(1);
          end
        end
        StSrClear: begin
          state_q     <= StShiftLo;
          sr_reset_q  <= 1'b0;
          sr_enable_q <= 1'b1;
        end
        StShiftLo: begin
          if (sr_phase_end) state_q <= StShiftHi;
        end
        StShiftHi: begin
          if (sr_done) begin
            state_q     <= StSrFinish;
            sr_enable_q <= 1'b0;
          end else if (sr_phase_end) begin
            state_q <= StShiftLo;
          end
        end
        StSrFinish: begin
          state_q          <= StCntReset;
          timer_q          <= '0;
          ext_reset_q      <= 1'b1;
          loaded_divisor_q <= sr_shadow;
          loaded_valid_q   <= 1'b1;
        end
        StCntReset: begin
          if (timer_q == ResetLast) begin
            state_q     <= StIdle;
            ext_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TimW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy               = busy_q;
  assign load_done          = load_done_q;
  assign cfg_error          = cfg_error_q;
  assign loaded_divisor     = loaded_divisor_q;
  assign div_enable         = enable_q;
  assign div_external_reset = ext_reset_q;
  assign div_sr_enable      = sr_enable_q;
  assign div_sr_reset       = sr_reset_q;

endmodule

// File: tb/tb_divider_config_sequencer.sv
// Directed bench for divider_config_sequencer with a scoreboard of expected SR payloads.
module tb_divider_config_sequencer;

  localparam int unsigned W = 32;

  logic         sys_clock = 1'b0;
  logic         sys_reset_n;
  logic [W-1:0] cfg_divisor;
  logic         cfg_valid, cfg_ready, counter_restart, run_request;
  logic         busy, load_done, cfg_error;
  logic [W-1:0] loaded_divisor;
  logic         div_enable, div_external_reset, div_sr_data, div_sr_data_clock;
  logic         div_sr_enable, div_sr_reset;

  divider_config_sequencer dut (
    .sys_clock          (sys_clock),
    .sys_reset_n        (sys_reset_n),
    .cfg_divisor        (cfg_divisor),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .counter_restart    (counter_restart),
    .run_request        (run_request),
    .busy               (busy),
    .load_done          (load_done),
    .cfg_error          (cfg_error),
    .loaded_divisor     (loaded_divisor),
    .div_enable         (div_enable),
    .div_external_reset (div_external_reset),
    .div_sr_data        (div_sr_data),
    .div_sr_data_clock  (div_sr_data_clock),
    .div_sr_enable      (div_sr_enable),
    .div_sr_reset       (div_sr_reset)
  );

  always #5 sys_clock = ~sys_clock;

  int cyc = 0;
  always @(posedge sys_clock) cyc <= cyc + 1;

  logic [8:0] out_vec;
  assign out_vec = {busy, load_done, cfg_error, div_enable, div_external_reset, div_sr_data,
                    div_sr_data_clock, div_sr_enable, div_sr_reset};

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  // SR-side monitor, sampled on the falling edge.
  logic         prev_sclk = 1'b0;
  logic [W-1:0] mon_word = '0;
  int mon_bits = 0, mon_srst = 0, mon_xrst = 0, mon_en_busy = 0;

  always @(negedge sys_clock) begin
    if (div_sr_data_clock && !prev_sclk) begin
      mon_word = {mon_word[W-2:0], div_sr_data};
      mon_bits++;
    end
    prev_sclk = div_sr_data_clock;
    if (div_sr_reset) mon_srst++;
    if (div_external_reset) mon_xrst++;
    if (div_enable && busy) mon_en_busy++;
  end

  task automatic mon_clear();
    mon_word = '0; mon_bits = 0; mon_srst = 0; mon_xrst = 0; mon_en_busy = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic wait_done(input int limit, output int t, output bit ok, output int bad,
                           output logic en_at_done);
    ok = 0; t = -1; bad = 0; en_at_done = 1'bx;
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clock);
      if (load_done) begin
        ok = 1; t = cyc; en_at_done = div_enable;
        break;
      end
      if (cfg_ready || !busy) bad++;
    end
  endtask

  // Waits for load_done of a full reload accepted in cycle n and checks the scoreboard.
  task automatic finish_load(input string tag, input int n, input logic [W-1:0] exp_div,
                             output int t);
    bit ok; int bad; logic en; logic [W-1:0] exp_word;
    wait_done(120, t, ok, bad, en);
    check({tag, " done seen"}, 64'(ok), 64'd1);
    check({tag, " latency"}, 64'(t - n), 64'd70);
    check({tag, " ready low while busy"}, 64'(bad), 64'd0);
    check({tag, " enable low at done"}, 64'(en), 64'd0);
    tick();
    exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check({tag, " sr bit count"}, 64'(mon_bits), 64'd32);
    check({tag, " sr word"}, 64'(mon_word), 64'(exp_word));
    check({tag, " sr reset cycles"}, 64'(mon_srst), 64'd1);
    check({tag, " ext reset cycles"}, 64'(mon_xrst), 64'd2);
    check({tag, " enable while busy"}, 64'(mon_en_busy), 64'd0);
    check({tag, " loaded_divisor"}, 64'(loaded_divisor), 64'(exp_div));
    mon_clear();
  endtask

  initial begin
    int n, t;
    bit ok;
    int bad, cnt;
    logic en;

    sys_reset_n = 1'b0; cfg_valid = 1'b0; cfg_divisor = '0;
    counter_restart = 1'b0; run_request = 1'b1;
    repeat (3) @(posedge sys_clock);
    @(negedge sys_clock);
    check("reset outputs", 64'(out_vec), 64'd0);
    check("reset loaded_divisor", 64'(loaded_divisor), 64'd0);
    #1 sys_reset_n = 1'b1;
    repeat (4) @(negedge sys_clock);
    check("no load outputs", 64'(out_vec), 64'd0);
    check("no load cfg_ready", 64'(cfg_ready), 64'd1);

    // First load of 20 with run_request high.
    tick(); mon_clear();
    cfg_divisor = 32'd20; cfg_valid = 1'b1; exp_q.push_back(32'd20); n = cyc;
    tick(); cfg_valid = 1'b0;
    @(negedge sys_clock);
    check("accept busy", 64'(busy), 64'd1);
    check("accept cfg_ready", 64'(cfg_ready), 64'd0);
    finish_load("load20", n, 32'd20, t);
    @(negedge sys_clock);
    check("load20 enable after done", 64'(div_enable), 64'd1);

    // Reload 10 while running; valid held with a new divisor during busy.
    tick(); mon_clear();
    cfg_divisor = 32'd10; cfg_valid = 1'b1; exp_q.push_back(32'd10); n = cyc;
    tick(); cfg_divisor = 32'd12; exp_q.push_back(32'd12);
    @(negedge sys_clock);
    check("reload enable drop", 64'(div_enable), 64'd0);
    finish_load("load10", n, 32'd10, t);
    cfg_valid = 1'b0;
    finish_load("held12", t, 32'd12, t);
    @(negedge sys_clock);
    check("held12 enable after done", 64'(div_enable), 64'd1);

    // Rejected divisors 0 and 1.
    for (int d = 0; d < 2; d++) begin
      tick(); cfg_divisor = W'(d); cfg_valid = 1'b1;
      tick(); cfg_valid = 1'b0;
      @(negedge sys_clock);
      check($sformatf("reject %0d error pulse", d), 64'(cfg_error), 64'd1);
      check($sformatf("reject %0d not busy", d), 64'(busy), 64'd0);
      @(negedge sys_clock);
      check($sformatf("reject %0d error width", d), 64'(cfg_error), 64'd0);
      check($sformatf("reject %0d still running", d), 64'(div_enable), 64'd1);
    end
    tick();
    check("reject no sr clocks", 64'(mon_bits), 64'd0);
    check("reject no sr reset", 64'(mon_srst), 64'd0);
    check("reject loaded_divisor", 64'(loaded_divisor), 64'd12);

    // Minimum accepted divisor.
    mon_clear(); cfg_divisor = 32'd2; cfg_valid = 1'b1; exp_q.push_back(32'd2); n = cyc;
    tick(); cfg_valid = 1'b0;
    finish_load("load2", n, 32'd2, t);

    // Counter-only restart.
    tick(); mon_clear(); counter_restart = 1'b1; n = cyc;
    tick(); counter_restart = 1'b0;
    wait_done(20, t, ok, bad, en);
    check("restart done seen", 64'(ok), 64'd1);
    check("restart latency", 64'(t - n), 64'd3);
    tick();
    check("restart ext reset cycles", 64'(mon_xrst), 64'd2);
    check("restart no sr clocks", 64'(mon_bits), 64'd0);
    check("restart no sr reset", 64'(mon_srst), 64'd0);
    check("restart loaded_divisor", 64'(loaded_divisor), 64'd2);

    // Restart coincident with accept: one full reload only.
    tick(); mon_clear();
    cfg_divisor = 32'd9; cfg_valid = 1'b1; counter_restart = 1'b1;
    exp_q.push_back(32'd9); n = cyc;
    tick(); cfg_valid = 1'b0; counter_restart = 1'b0;
    finish_load("restart+accept", n, 32'd9, t);
    cnt = 0;
    repeat (10) begin
      @(negedge sys_clock);
      if (load_done || busy) cnt++;
    end
    check("restart+accept no second op", 64'(cnt), 64'd0);

    // Async reset while bit 17 is being shifted.
    tick(); mon_clear();
    cfg_divisor = 32'd25; cfg_valid = 1'b1; exp_q.push_back(32'd25);
    tick(); cfg_valid = 1'b0;
    for (int i = 0; i < 100 && mon_bits < 14; i++) tick();
    check("abort reached bit 17", 64'(mon_bits), 64'd14);
    #2 sys_reset_n = 1'b0;
    #1;
    check("abort outputs", 64'(out_vec), 64'd0);
    check("abort loaded_divisor", 64'(loaded_divisor), 64'd0);
    check("abort cfg_ready", 64'(cfg_ready), 64'd1);
    void'(exp_q.pop_front());
    @(negedge sys_clock);
    #1 sys_reset_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge sys_clock);
      if (div_enable) cnt++;
    end
    check("abort enable stays low", 64'(cnt), 64'd0);
    tick(); counter_restart = 1'b1;
    tick(); counter_restart = 1'b0;
    @(negedge sys_clock);
    check("abort restart ignored", 64'(busy), 64'd0);
    tick(); mon_clear();
    cfg_divisor = 32'd20; cfg_valid = 1'b1; exp_q.push_back(32'd20); n = cyc;
    tick(); cfg_valid = 1'b0;
    finish_load("reload after abort", n, 32'd20, t);
    @(negedge sys_clock);
    check("reload after abort enable", 64'(div_enable), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish before 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule
